lcd_char_scheduler: RTL and testbench

- Buffers received UART bytes and feeds them to the LCD character controller one at a time.
- Drives the controller's byte/strobe inputs and obeys its busy handshake.
- Arbitrates between the UART byte stream and a high-priority display-clear request.
- Sits between the UART receiver and the LCD controller.

---
 rtl/lcd_char_scheduler.sv | 156 +++++++++++++++
 tb/tb_lcd_char_scheduler.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_char_scheduler.sv
// Queues UART bytes and feeds them one at a time to the LCD character controller,
// injecting a display-clear code on request and pacing strobes on the busy handshake.
module lcd_char_scheduler #(
  parameter int DEPTH  = 16,
  parameter int AW     = 4,
  parameter int GUARD  = 4,
  parameter int ACK_TO = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [7:0]    rx_data_i,
  input  logic          rx_valid_i,
  output logic          rx_ready_o,
  input  logic          clr_req_i,
  input  logic          lcd_busy_i,
  output logic [7:0]    lcd_data_o,
  output logic          lcd_strobe_o,
  output logic [AW:0]   fifo_count_o,
  output logic          overflow_o,
  output logic          ack_err_o
);

  localparam int TMAX = (GUARD > ACK_TO) ? GUARD : ACK_TO;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [7:0] CLEAR_CODE = 8'h0D;

  typedef enum logic [2:0] {
    INIT_WAIT,
    IDLE,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE
  } state_e;

  state_e        state_q;
  logic [TW-1:0] timer_q;
  logic [7:0]    data_q;
  logic          strobe_q;
  logic          ack_err_q;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          clr_pend_q, clr_pend_d;
  logic          overflow_q, overflow_d;

  logic full, empty, push, pop, can_issue, issue_clr;

  assign full      = (count_q == (AW+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign can_issue = (state_q == IDLE) && !lcd_busy_i;
  // A clear arriving in the same cycle as an issue decision pre-empts the head byte.
  assign issue_clr = can_issue && (clr_pend_q || clr_req_i);
  assign pop       = can_issue && !issue_clr && !empty;
  assign push      = rx_valid_i && !full && !clr_req_i;

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    clr_pend_d = clr_pend_q;
    overflow_d = overflow_q | (rx_valid_i && full && !clr_req_i);
    if (clr_req_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
      count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
    if (issue_clr)      clr_pend_d = 1'b0;
    else if (clr_req_i) clr_pend_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= rx_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      clr_pend_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      clr_pend_q <= clr_pend_d;
      overflow_q <= overflow_d;
    end
  end

  // The controller reports not-busy briefly after reset, so busy is ignored until GUARD expires.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= INIT_WAIT;
      timer_q   <= '0;
      data_q    <= '0;
      strobe_q  <= 1'b0;
      ack_err_q <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      case (state_q)
        INIT_WAIT: begin
          if (timer_q == TW'(GUARD - 1)) begin
            timer_q <= '0;
            state_q <= IDLE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        IDLE: begin
          if (issue_clr) begin
            data_q   <= CLEAR_CODE;
            strobe_q <= 1'b1;
            state_q  <= ISSUE;
          end else if (pop) begin
            data_q   <= mem_q[rptr_q];
            strobe_q <= 1'b1;
            state_q  <= ISSUE;
          end
        end
        ISSUE: begin
          timer_q <= '0;
          state_q <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (lcd_busy_i) begin
            state_q <= WAIT_DONE;
          end else if (timer_q == TW'(ACK_TO - 1)) begin
            ack_err_q <= 1'b1;
            state_q   <= IDLE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!lcd_busy_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_ready_o   = !full;
  assign lcd_data_o   = data_q;
  assign lcd_strobe_o = strobe_q;
  assign fifo_count_o = count_q;
  assign overflow_o   = overflow_q;
  assign ack_err_o    = ack_err_q;

endmodule

// File: tb/tb_lcd_char_scheduler.sv
// Self-checking bench for lcd_char_scheduler: a queue-based model predicts the byte
// order and FIFO occupancy while a behavioural LCD busy model answers each strobe.
module tb_lcd_char_scheduler;

  localparam int DEPTH  = 16;
  localparam int AW     = 4;
  localparam int GUARD  = 4;
  localparam int ACK_TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rxData = 8'h00;
  logic        rxValid = 1'b0;
  logic        clrReq = 1'b0;
  logic        manualBusy = 1'b0;
  logic        autoBusy = 1'b0;
  int          busyMode = 0;
  logic        lcdBusy;
  logic        rxReady;
  logic [7:0]  lcdData;
  logic        lcdStrobe;
  logic [AW:0] fifoCount;
  logic        overflow;
  logic        ackErr;

  int testsRun = 0;
  int testsFailed = 0;

  logic [7:0] fifoQ[$];
  bit         modelPend = 1'b0;
  bit         modelOverflow = 1'b0;
  logic [7:0] obsData[$];
  logic [7:0] expData[$];
  int         strobeCycle[$];
  int         cycleCnt = 0;
  int         consecViol = 0;
  bit         lastStrobe = 1'b0;
  int         autoPend = 0;
  int         autoHold = 0;

  // busyMode: 0 = bench drives busy directly, 1 = nominal controller, 2 = controller never answers
  assign lcdBusy = (busyMode == 0) ? manualBusy : ((busyMode == 1) ? autoBusy : 1'b0);

  lcd_char_scheduler #(.DEPTH(DEPTH), .AW(AW), .GUARD(GUARD), .ACK_TO(ACK_TO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .rx_data_i(rxData), .rx_valid_i(rxValid),
    .rx_ready_o(rxReady), .clr_req_i(clrReq), .lcd_busy_i(lcdBusy),
    .lcd_data_o(lcdData), .lcd_strobe_o(lcdStrobe), .fifo_count_o(fifoCount),
    .overflow_o(overflow), .ack_err_o(ackErr)
  );

  always #5 clk = ~clk;

  // Reference model: inputs taken at the edge, strobes logged just after it.
  always @(posedge clk) begin
    if (!rst_n) begin
      fifoQ.delete();
      modelPend = 1'b0;
      modelOverflow = 1'b0;
    end else if (clrReq) begin
      fifoQ.delete();
      modelPend = 1'b1;
    end else if (rxValid) begin
      if (fifoQ.size() < DEPTH) fifoQ.push_back(rxData);
      else modelOverflow = 1'b1;
    end
    #1;
    cycleCnt++;
    if (lcdStrobe) begin
      obsData.push_back(lcdData);
      strobeCycle.push_back(cycleCnt);
      if (modelPend) begin
        expData.push_back(8'h0D);
        modelPend = 1'b0;
      end else if (fifoQ.size() > 0) begin
        expData.push_back(fifoQ.pop_front());
      end else begin
        expData.push_back(8'hxx);
      end
      if (lastStrobe) consecViol++;
    end
    lastStrobe = lcdStrobe;
  end

  // Nominal controller: busy rises two cycles after a strobe and stays high for 20 cycles.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      autoBusy = 1'b0;
      autoPend = 0;
      autoHold = 0;
    end else begin
      if (autoHold > 0) begin
        autoHold--;
        if (autoHold == 0) autoBusy = 1'b0;
      end
      if (autoPend > 0) begin
        autoPend--;
        if (autoPend == 0) begin
          autoBusy = 1'b1;
          autoHold = 20;
        end
      end
      if (lcdStrobe && busyMode == 1) autoPend = 2;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pushByte(input logic [7:0] b);
    rxData = b;
    rxValid = 1'b1;
    @(negedge clk);
    rxValid = 1'b0;
  endtask

  task automatic pulseClear();
    clrReq = 1'b1;
    @(negedge clk);
    clrReq = 1'b0;
  endtask

  task automatic clearLogs();
    obsData.delete();
    expData.delete();
    strobeCycle.delete();
    consecViol = 0;
  endtask

  task automatic waitStrobes(input int n, input int budget, output bit ok);
    int c = 0;
    while (obsData.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    ok = (obsData.size() >= n);
  endtask

  task automatic test_reset();
    testsRun++; if (lcdData !== 8'h00) begin testsFailed++; $display("[TB] FAIL reset_data: got %h want 00", lcdData); end
    testsRun++; if (lcdStrobe !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_strobe: got %b want 0", lcdStrobe); end
    testsRun++; if (fifoCount !== 5'd0) begin testsFailed++; $display("[TB] FAIL reset_count: got %0d want 0", fifoCount); end
    testsRun++; if (overflow !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_overflow: got %b want 0", overflow); end
    testsRun++; if (ackErr !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_ack_err: got %b want 0", ackErr); end
    testsRun++; if (rxReady !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_rx_ready: got %b want 1", rxReady); end
  endtask

  task automatic test_busy_hold();
    bit ok;
    busyMode = 0;
    manualBusy = 1'b1;
    clearLogs();
    rst_n = 1'b1;
    tick(10);
    pushByte(8'h41);
    tick(39);
    testsRun++; if (obsData.size() != 0) begin testsFailed++; $display("[TB] FAIL busy_hold_no_strobe: got %0d strobes want 0", obsData.size()); end
    testsRun++; if (fifoCount !== 5'd1) begin testsFailed++; $display("[TB] FAIL busy_hold_count: got %0d want 1", fifoCount); end
    manualBusy = 1'b0;
    waitStrobes(1, 20, ok);
    testsRun++; if (!ok) begin testsFailed++; $display("[TB] FAIL busy_hold_strobe_seen: got 0 strobes want 1"); end
    testsRun++; if (obsData[0] !== 8'h41) begin testsFailed++; $display("[TB] FAIL busy_hold_data: got %h want 41", obsData[0]); end
    tick(1);
    testsRun++; if (lcdStrobe !== 1'b0) begin testsFailed++; $display("[TB] FAIL busy_hold_strobe_width: got %b want 0", lcdStrobe); end
    testsRun++; if (lcdData !== 8'h41) begin testsFailed++; $display("[TB] FAIL busy_hold_data_held1: got %h want 41", lcdData); end
    tick(1);
    manualBusy = 1'b1;
    tick(1);
    testsRun++; if (lcdData !== 8'h41) begin testsFailed++; $display("[TB] FAIL busy_hold_data_held2: got %h want 41", lcdData); end
    tick(5);
    manualBusy = 1'b0;
    tick(10);
    testsRun++; if (obsData.size() != 1) begin testsFailed++; $display("[TB] FAIL busy_hold_one_strobe: got %0d want 1", obsData.size()); end
    testsRun++; if (fifoCount !== 5'd0) begin testsFailed++; $display("[TB] FAIL busy_hold_count_end: got %0d want 0", fifoCount); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] want [3];
    bit ok;
    want[0] = 8'h48; want[1] = 8'h49; want[2] = 8'h21;
    busyMode = 1;
    clearLogs();
    for (int i = 0; i < 3; i++) pushByte(want[i]);
    waitStrobes(3, 150, ok);
    testsRun++; if (!ok) begin testsFailed++; $display("[TB] FAIL b2b_strobes_seen: got %0d want 3", obsData.size()); end
    tick(30);
    testsRun++; if (obsData.size() != 3) begin testsFailed++; $display("[TB] FAIL b2b_strobe_count: got %0d want 3", obsData.size()); end
    for (int i = 0; i < 3; i++) begin
      testsRun++; if (obsData[i] !== want[i]) begin testsFailed++; $display("[TB] FAIL b2b_data%0d: got %h want %h", i, obsData[i], want[i]); end
      testsRun++; if (obsData[i] !== expData[i]) begin testsFailed++; $display("[TB] FAIL b2b_model%0d: got %h want %h", i, obsData[i], expData[i]); end
    end
    for (int i = 1; i < 3; i++) begin
      testsRun++; if (!(strobeCycle[i] - strobeCycle[i-1] >= 23)) begin testsFailed++; $display("[TB] FAIL b2b_gap%0d: got %0d want >=23", i, strobeCycle[i] - strobeCycle[i-1]); end
    end
    testsRun++; if (fifoCount !== 5'd0) begin testsFailed++; $display("[TB] FAIL b2b_count_end: got %0d want 0", fifoCount); end
    testsRun++; if (consecViol != 0) begin testsFailed++; $display("[TB] FAIL b2b_consecutive: got %0d want 0", consecViol); end
  endtask

  task automatic test_overflow();
    logic [7:0] bytes [17];
    bit ok;
    busyMode = 0;
    manualBusy = 1'b1;
    clearLogs();
    for (int i = 0; i < 17; i++) bytes[i] = 8'($urandom);
    for (int i = 0; i < 17; i++) pushByte(bytes[i]);
    testsRun++; if (fifoCount !== 5'd16) begin testsFailed++; $display("[TB] FAIL ovf_count: got %0d want 16", fifoCount); end
    testsRun++; if (rxReady !== 1'b0) begin testsFailed++; $display("[TB] FAIL ovf_rx_ready: got %b want 0", rxReady); end
    testsRun++; if (overflow !== 1'b1) begin testsFailed++; $display("[TB] FAIL ovf_flag: got %b want 1", overflow); end
    busyMode = 1;
    waitStrobes(16, 16 * 30, ok);
    tick(60);
    testsRun++; if (obsData.size() != 16) begin testsFailed++; $display("[TB] FAIL ovf_strobe_count: got %0d want 16", obsData.size()); end
    for (int i = 0; i < 16; i++) begin
      testsRun++; if (obsData[i] !== bytes[i]) begin testsFailed++; $display("[TB] FAIL ovf_data%0d: got %h want %h", i, obsData[i], bytes[i]); end
    end
    testsRun++; if (fifoCount !== 5'd0) begin testsFailed++; $display("[TB] FAIL ovf_count_end: got %0d want 0", fifoCount); end
  endtask

  task automatic test_clear();
    logic [7:0] a, b;
    bit ok;
    busyMode = 0;
    manualBusy = 1'b1;
    clearLogs();
    for (int i = 0; i < 5; i++) pushByte(8'($urandom));
    testsRun++; if (fifoCount !== 5'd5) begin testsFailed++; $display("[TB] FAIL clr_count_before: got %0d want 5", fifoCount); end
    pulseClear();
    testsRun++; if (fifoCount !== 5'd0) begin testsFailed++; $display("[TB] FAIL clr_count_after: got %0d want 0", fifoCount); end
    a = 8'($urandom);
    b = 8'($urandom);
    pushByte(a);
    pushByte(b);
    busyMode = 1;
    waitStrobes(3, 120, ok);
    tick(40);
    testsRun++; if (obsData.size() != 3) begin testsFailed++; $display("[TB] FAIL clr_strobe_count: got %0d want 3", obsData.size()); end
    testsRun++; if (obsData[0] !== 8'h0D) begin testsFailed++; $display("[TB] FAIL clr_code: got %h want 0d", obsData[0]); end
    testsRun++; if (obsData[1] !== a) begin testsFailed++; $display("[TB] FAIL clr_next1: got %h want %h", obsData[1], a); end
    testsRun++; if (obsData[2] !== b) begin testsFailed++; $display("[TB] FAIL clr_next2: got %h want %h", obsData[2], b); end
    testsRun++; if (overflow !== 1'b1) begin testsFailed++; $display("[TB] FAIL clr_overflow_sticky: got %b want 1", overflow); end
  endtask

  task automatic test_ack_timeout();
    logic [7:0] b0, b1;
    int s;
    bit ok;
    busyMode = 0;
    manualBusy = 1'b1;
    clearLogs();
    b0 = 8'($urandom);
    b1 = 8'($urandom);
    pushByte(b0);
    pushByte(b1);
    busyMode = 2;
    waitStrobes(1, 20, ok);
    testsRun++; if (!ok) begin testsFailed++; $display("[TB] FAIL ack_first_strobe: got 0 strobes want 1"); end
    s = (strobeCycle.size() > 0) ? strobeCycle[0] : 0;
    testsRun++; if (obsData[0] !== b0) begin testsFailed++; $display("[TB] FAIL ack_first_data: got %h want %h", obsData[0], b0); end
    while (cycleCnt < s + ACK_TO) @(negedge clk);
    testsRun++; if (ackErr !== 1'b0) begin testsFailed++; $display("[TB] FAIL ack_err_early: got %b want 0", ackErr); end
    @(negedge clk);
    testsRun++; if (ackErr !== 1'b1) begin testsFailed++; $display("[TB] FAIL ack_err_set: got %b want 1", ackErr); end
    waitStrobes(2, 10, ok);
    testsRun++; if (obsData[1] !== b1) begin testsFailed++; $display("[TB] FAIL ack_next_data: got %h want %h", obsData[1], b1); end
    testsRun++; if (strobeCycle[1] != s + ACK_TO + 2) begin testsFailed++; $display("[TB] FAIL ack_next_cycle: got %0d want %0d", strobeCycle[1], s + ACK_TO + 2); end
    tick(ACK_TO + 5);
  endtask

  task automatic test_reset_midflight();
    int rel;
    bit ok;
    busyMode = 2;
    clearLogs();
    pushByte(8'h5A);
    pushByte(8'($urandom));
    pushByte(8'($urandom));
    waitStrobes(1, 20, ok);
    tick(2);
    testsRun++; if (fifoCount !== 5'd2) begin testsFailed++; $display("[TB] FAIL mid_count_before: got %0d want 2", fifoCount); end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    testsRun++; if (lcdData !== 8'h00) begin testsFailed++; $display("[TB] FAIL mid_reset_data: got %h want 00", lcdData); end
    testsRun++; if (fifoCount !== 5'd0) begin testsFailed++; $display("[TB] FAIL mid_reset_count: got %0d want 0", fifoCount); end
    testsRun++; if (overflow !== 1'b0) begin testsFailed++; $display("[TB] FAIL mid_reset_overflow: got %b want 0", overflow); end
    testsRun++; if (ackErr !== 1'b0) begin testsFailed++; $display("[TB] FAIL mid_reset_ack_err: got %b want 0", ackErr); end
    testsRun++; if (rxReady !== 1'b1) begin testsFailed++; $display("[TB] FAIL mid_reset_rx_ready: got %b want 1", rxReady); end
    tick(3);
    busyMode = 0;
    manualBusy = 1'b0;
    clearLogs();
    rst_n = 1'b1;
    rel = cycleCnt;
    pushByte(8'h37);
    tick(GUARD - 1);
    testsRun++; if (obsData.size() != 0) begin testsFailed++; $display("[TB] FAIL mid_guard_no_strobe: got %0d strobes want 0", obsData.size()); end
    waitStrobes(1, 10, ok);
    testsRun++; if (obsData[0] !== 8'h37) begin testsFailed++; $display("[TB] FAIL mid_after_data: got %h want 37", obsData[0]); end
    testsRun++; if (strobeCycle[0] != rel + GUARD + 1) begin testsFailed++; $display("[TB] FAIL mid_after_cycle: got %0d want %0d", strobeCycle[0], rel + GUARD + 1); end
    tick(ACK_TO + 5);
  endtask

  task automatic test_random();
    int c = 0;
    int countErr = 0;
    busyMode = 1;
    manualBusy = 1'b0;
    clearLogs();
    for (int i = 0; i < 400; i++) begin
      rxValid = ($urandom_range(0, 99) < 35);
      rxData  = 8'($urandom);
      clrReq  = ($urandom_range(0, 99) < 2);
      @(negedge clk);
      testsRun++; if (fifoCount !== (AW+1)'(fifoQ.size())) begin testsFailed++; countErr++; if (countErr < 5) $display("[TB] FAIL rnd_count: got %0d want %0d", fifoCount, fifoQ.size()); end
    end
    rxValid = 1'b0;
    clrReq = 1'b0;
    while ((fifoQ.size() > 0 || modelPend) && c < 1000) begin
      @(negedge clk);
      c++;
    end
    tick(40);
    testsRun++; if (c >= 1000) begin testsFailed++; $display("[TB] FAIL rnd_drain: got timeout want drained"); end
    testsRun++; if (obsData.size() != expData.size()) begin testsFailed++; $display("[TB] FAIL rnd_len: got %0d want %0d", obsData.size(), expData.size()); end
    for (int i = 0; i < obsData.size(); i++) begin
      testsRun++; if (obsData[i] !== expData[i]) begin testsFailed++; $display("[TB] FAIL rnd_data%0d: got %h want %h", i, obsData[i], expData[i]); end
    end
    testsRun++; if (overflow !== modelOverflow) begin testsFailed++; $display("[TB] FAIL rnd_overflow: got %b want %b", overflow, modelOverflow); end
    testsRun++; if (consecViol != 0) begin testsFailed++; $display("[TB] FAIL rnd_consecutive: got %0d want 0", consecViol); end
  endtask

  initial begin
    tick(2);
    test_reset();
    test_busy_hold();
    test_back_to_back();
    test_overflow();
    test_clear();
    test_ack_timeout();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
